// File: rtl/worm_rate_scheduler.sv
// -----------------------------------------------------------------------------
// worm_rate_scheduler
//
// Sequences the LED worm display from the single free-running clock inClk.
// The two raw push buttons are synchronized, debounced and edge-detected.
// Each accepted press steps a one-hot speed state (fast / medium / slow).
// The block emits a one-cycle rotation strobe at the selected rate. It also
// owns the worm position counter and the active-low digit-select drive.
// No clock is ever gated or derived. Every rate is a strobe in inClk's domain.
//
// Parameters
//   TICK_DIV         inClk cycles per fast-rate tick (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable synchronized cycles needed to accept
//                    a button level change (>= 1)
//
// Ports
//   inClk        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   buttonA      in   raw button, a press steps the speed forward
//   buttonB      in   raw button, a press steps the speed backward
//   clockSelect  out  one-hot speed: 100 fast, 010 medium, 001 slow
//   rotTick      out  registered one-cycle strobe that advances the rotator
//   wormDir      out  0 = position increasing, 1 = position decreasing
//   wormPos      out  current worm digit index 0..3
//   LEDSEL       out  active-low one-hot digit select, ~(4'b0001 << wormPos)
// -----------------------------------------------------------------------------
module worm_rate_scheduler #(
   parameter int TICK_DIV        = 16666667,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       inClk,
   input  logic       reset,
   input  logic       buttonA,
   input  logic       buttonB,
   output logic [2:0] clockSelect,
   output logic       rotTick,
   output logic       wormDir,
   output logic [1:0] wormPos,
   output logic [3:0] LEDSEL
);

   localparam int BASE_W = $clog2(TICK_DIV);
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [2:0] {
      FAST = 3'b100,
      MED  = 3'b010,
      SLOW = 3'b001
   } speed_t;

   // ---------------------------------------------------------------------------
   // Input conditioning. Index 0 is buttonA and index 1 is buttonB.
   // ---------------------------------------------------------------------------
   logic [1:0]           sync1;
   logic [1:0]           sync2;
   logic [1:0]           stable;
   logic [1:0]           press;
   logic [1:0][DB_W-1:0] db_cnt;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge inClk or posedge reset) begin
      if (reset) begin
         // NOTE: every register is reset, including the debounce counter array.
         // No flop may power up with a stale count or level.
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         press  <= '0;
         db_cnt <= '0;
      end else begin
         sync1 <= {buttonB, buttonA};
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
               // The pulse fires only when the stable level is accepted as
               // high, so a release never produces an event.
               press[i]  <= sync2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   wire press_a = press[0];
   wire press_b = press[1];

   // ---------------------------------------------------------------------------
   // Speed next-state decode.
   // ---------------------------------------------------------------------------
   // The state is held as a raw vector, not as the enum type. An upset can then
   // leave it in a non-one-hot value, and the default arm recovers from that.
   logic [2:0] sel_q;
   speed_t     sel_next;

   always_comb begin
      // NOTE: the default assignment first keeps every path assigned, so no
      // latch is inferred. It also makes illegal encodings fall back to FAST.
      sel_next = FAST;
      case (sel_q)
         FAST: begin
            if (press_a && !press_b)      sel_next = MED;
            else if (press_b && !press_a) sel_next = SLOW;
            else                          sel_next = FAST;
         end
         MED: begin
            if (press_a && !press_b)      sel_next = SLOW;
            else if (press_b && !press_a) sel_next = FAST;
            else                          sel_next = MED;
         end
         SLOW: begin
            if (press_a && !press_b)      sel_next = FAST;
            else if (press_b && !press_a) sel_next = MED;
            else                          sel_next = SLOW;
         end
         default: sel_next = FAST;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Rate generation and position.
   // ---------------------------------------------------------------------------
   logic [BASE_W-1:0] base_cnt;
   logic [1:0]        sub_cnt;
   logic              base_tick;
   logic              rate_hit;
   logic [1:0]        pos_next;

   assign base_tick = (base_cnt == BASE_W'(TICK_DIV - 1));

   // The decision uses the current (pre-update) speed and sub-count. Medium
   // fires on every second base tick and slow on every fourth.
   assign rate_hit = (sel_q == FAST)
                   | ((sel_q == MED)  & sub_cnt[0])
                   | ((sel_q == SLOW) & (sub_cnt == 2'b11));

   assign pos_next = wormDir ? (wormPos - 2'd1) : (wormPos + 2'd1);

   always_ff @(posedge inClk or posedge reset) begin
      if (reset) begin
         sel_q    <= FAST;
         rotTick  <= 1'b0;
         wormDir  <= 1'b0;
         wormPos  <= 2'd0;
         LEDSEL   <= 4'b1110;
         base_cnt <= '0;
         sub_cnt  <= 2'd0;
      end else begin
         // The base counter free-runs and is never realigned by speed changes.
         base_cnt <= base_tick ? '0 : base_cnt + 1'b1;
         rotTick  <= base_tick & rate_hit;
         sel_q    <= sel_next;

         // A speed change restarts the divided cadence from a clean phase.
         if (sel_next != sel_q) begin
            sub_cnt <= 2'd0;
         end else if (base_tick) begin
            sub_cnt <= sub_cnt + 2'd1;
         end

         if (press_a && press_b) begin
            wormDir <= ~wormDir;
         end

         // pos_next uses the pre-edge wormDir. A toggle on the same edge
         // therefore takes effect from the following step.
         if (rotTick) begin
            wormPos <= pos_next;
            LEDSEL  <= ~(4'b0001 << pos_next);
         end
      end
   end

   assign clockSelect = sel_q;

endmodule

// File: tb/tb_worm_rate_scheduler.sv
// -----------------------------------------------------------------------------
// tb_worm_rate_scheduler
//
// Self-checking bench for worm_rate_scheduler with TICK_DIV=4 and
// DEBOUNCE_CYCLES=3. A behavioural model steps on every rising edge. It tracks
// the rate as a speed index and a power-of-two divisor, and the position as
// modular arithmetic. A compare process checks every DUT output against the
// model on each falling edge. Directed phases pin the model with literal
// expectations. A randomized button phase follows.
// -----------------------------------------------------------------------------
module tb_worm_rate_scheduler;

   localparam int TICK_DIV = 4;
   localparam int DB       = 3;

   logic       inClk   = 1'b0;
   logic       reset   = 1'b0;
   logic       buttonA = 1'b0;
   logic       buttonB = 1'b0;
   logic [2:0] clockSelect;
   logic       rotTick;
   logic       wormDir;
   logic [1:0] wormPos;
   logic [3:0] LEDSEL;

   worm_rate_scheduler #(
      .TICK_DIV        (TICK_DIV),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .inClk       (inClk),
      .reset       (reset),
      .buttonA     (buttonA),
      .buttonB     (buttonB),
      .clockSelect (clockSelect),
      .rotTick     (rotTick),
      .wormDir     (wormDir),
      .wormPos     (wormPos),
      .LEDSEL      (LEDSEL)
   );

   initial forever #5 inClk = ~inClk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model.
   // ---------------------------------------------------------------------------
   bit [2:0] m_sel    = 3'b100;
   int       m_base   = 0;
   int       m_sub    = 0;
   bit       m_tick   = 1'b0;
   bit       m_dir    = 1'b0;
   int       m_pos    = 0;
   bit [1:0] m_s1     = '0;
   bit [1:0] m_s2     = '0;
   bit [1:0] m_stable = '0;
   bit [1:0] m_press  = '0;
   int       m_run[2] = '{0, 0};

   task automatic model_reset();
      m_sel = 3'b100; m_base = 0; m_sub = 0; m_tick = 1'b0; m_dir = 1'b0;
      m_pos = 0; m_s1 = '0; m_s2 = '0; m_stable = '0; m_press = '0;
      m_run[0] = 0; m_run[1] = 0;
   endtask

   task automatic model_step();
      int       idx;
      int       nidx;
      bit       base_wrap;
      bit       tick_n;
      bit [2:0] sel_n;
      int       sub_n;
      bit [1:0] press_n;
      bit       raw;
      bit       pa;
      bit       pb;
      pa = m_press[0];
      pb = m_press[1];
      case (m_sel)
         3'b100:  idx = 0;
         3'b010:  idx = 1;
         3'b001:  idx = 2;
         default: idx = -1;
      endcase
      base_wrap = (m_base == TICK_DIV - 1);
      // The speed index selects a divisor of 1, 2 or 4 base periods.
      tick_n = base_wrap && (idx >= 0) && (((m_sub + 1) % (1 << idx)) == 0);
      if (idx < 0)          nidx = 0;
      else if (pa && !pb)   nidx = (idx + 1) % 3;
      else if (pb && !pa)   nidx = (idx + 2) % 3;
      else                  nidx = idx;
      sel_n = 3'b100 >> nidx;
      sub_n = (sel_n != m_sel) ? 0 : (base_wrap ? (m_sub + 1) % 4 : m_sub);
      if (m_tick) m_pos = (m_pos + (m_dir ? 3 : 1)) % 4;
      if (pa && pb) m_dir = !m_dir;
      for (int i = 0; i < 2; i++) begin
         raw = (i == 0) ? buttonA : buttonB;
         press_n[i] = 1'b0;
         if (m_s2[i] == m_stable[i]) begin
            m_run[i] = 0;
         end else if (m_run[i] == DB - 1) begin
            m_stable[i] = m_s2[i];
            m_run[i]    = 0;
            press_n[i]  = m_s2[i];
         end else begin
            m_run[i] = m_run[i] + 1;
         end
         m_s2[i] = m_s1[i];
         m_s1[i] = raw;
      end
      m_press = press_n;
      m_base  = (m_base + 1) % TICK_DIV;
      m_sub   = sub_n;
      m_sel   = sel_n;
      m_tick  = tick_n;
   endtask

   initial forever begin
      @(posedge inClk or posedge reset);
      if (reset) model_reset();
      else       model_step();
   end

   // Compare process: all outputs against the model, away from the active edge.
   initial forever begin
      logic [3:0] exp_led;
      @(negedge inClk);
      if (cmp_en) begin
         exp_led = 4'hF ^ (4'd1 << m_pos);
         check("clockSelect", 32'(clockSelect), 32'(m_sel));
         check("rotTick",     32'(rotTick),     32'(m_tick));
         check("wormDir",     32'(wormDir),     32'(m_dir));
         check("wormPos",     32'(wormPos),     32'(m_pos));
         check("LEDSEL",      32'(LEDSEL),      32'(exp_led));
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers.
   // ---------------------------------------------------------------------------
   task automatic cycles(input int n);
      repeat (n) @(negedge inClk);
   endtask

   // Falling edges until rotTick is seen high, bounded by budget.
   task automatic wait_tick(input int budget, output int n);
      n = 0;
      forever begin
         @(negedge inClk);
         n++;
         if (rotTick === 1'b1) break;
         if (n >= budget) begin
            check("rotTick within budget", 32'(rotTick), 32'd1);
            break;
         end
      end
   endtask

   task automatic press(input bit a, input bit b, input int hold);
      @(negedge inClk);
      buttonA = a;
      buttonB = b;
      cycles(hold);
      buttonA = 1'b0;
      buttonB = 1'b0;
      cycles(10);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " clockSelect"}, 32'(clockSelect), 'b100);
      check({tag, " rotTick"},     32'(rotTick),     'b0);
      check({tag, " wormDir"},     32'(wormDir),     'b0);
      check({tag, " wormPos"},     32'(wormPos),     'd0);
      check({tag, " LEDSEL"},      32'(LEDSEL),      'b1110);
   endtask

   int n;
   int p;
   int exp_pos[5] = '{0, 1, 2, 3, 0};
   int exp_led[5] = '{'b1110, 'b1101, 'b1011, 'b0111, 'b1110};

   initial begin
      #1 reset = 1'b1;
      #2 cmp_en = 1'b1;
      cycles(2);
      check_reset_values("reset");

      // Free-run at FAST after a release between edges.
      @(posedge inClk);
      #2 reset = 1'b0;
      wait_tick(20, n);
      check("first tick cycle after release", 32'(n), TICK_DIV + 1);
      for (int k = 0; k < 5; k++) begin
         check("fast wormPos at tick", 32'(wormPos), 32'(exp_pos[k]));
         check("fast LEDSEL at tick",  32'(LEDSEL),  32'(exp_led[k]));
         if (k < 4) begin
            wait_tick(20, n);
            check("fast tick period", 32'(n), 4);
         end
      end

      // buttonA presses: FAST -> MED -> SLOW -> FAST.
      press(1'b1, 1'b0, 20);
      check("A press 1 clockSelect", 32'(clockSelect), 'b010);
      wait_tick(40, n);
      wait_tick(40, n);
      check("MED tick period", 32'(n), 8);
      press(1'b1, 1'b0, 20);
      check("A press 2 clockSelect", 32'(clockSelect), 'b001);
      wait_tick(40, n);
      wait_tick(40, n);
      check("SLOW tick period", 32'(n), 16);
      press(1'b1, 1'b0, 20);
      check("A press 3 clockSelect", 32'(clockSelect), 'b100);

      // Chatter shorter than the debounce window is ignored.
      for (int k = 0; k < 10; k++) begin
         @(negedge inClk);
         buttonA = ~buttonA;
      end
      buttonA = 1'b0;
      cycles(10);
      check("chatter clockSelect", 32'(clockSelect), 'b100);
      wait_tick(20, n);
      wait_tick(20, n);
      check("chatter tick period", 32'(n), 4);

      // buttonB from FAST goes to SLOW. A and B together toggle direction only.
      press(1'b0, 1'b1, 20);
      check("B press clockSelect", 32'(clockSelect), 'b001);
      press(1'b1, 1'b1, 20);
      check("A+B clockSelect", 32'(clockSelect), 'b001);
      check("A+B wormDir", 32'(wormDir), 'b1);
      wait_tick(40, n);
      p = int'(wormPos);
      wait_tick(40, n);
      check("down step 1", 32'(wormPos), 32'((p + 3) % 4));
      wait_tick(40, n);
      check("down step 2", 32'(wormPos), 32'((p + 2) % 4));

      // Asynchronous reset mid-cycle at wormPos=2 in SLOW.
      n = 0;
      while (wormPos !== 2'd2 && n < 200) begin
         @(negedge inClk);
         n++;
      end
      check("reached wormPos 2", 32'(wormPos), 'd2);
      check("pre-reset clockSelect", 32'(clockSelect), 'b001);
      @(posedge inClk);
      #2 reset = 1'b1;
      #1 check_reset_values("async reset");
      cycles(2);
      @(posedge inClk);
      #2 reset = 1'b0;
      wait_tick(20, n);
      check("first tick after mid reset", 32'(n), TICK_DIV + 1);

      // Illegal speed encodings recover to FAST on the next edge.
      @(negedge inClk);
      #2 force dut.sel_q = 3'b011;
      m_sel = 3'b011;
      #1 release dut.sel_q;
      #1 check("deposit 011 visible", 32'(clockSelect), 'b011);
      @(posedge inClk);
      #1 check("recover from 011", 32'(clockSelect), 'b100);
      @(negedge inClk);
      #2 force dut.sel_q = 3'b000;
      m_sel = 3'b000;
      #1 release dut.sel_q;
      #1 check("deposit 000 visible", 32'(clockSelect), 'b000);
      @(posedge inClk);
      #1 check("recover from 000", 32'(clockSelect), 'b100);

      // Randomized button activity against the model.
      repeat (150) begin
         int mode;
         int hold;
         int gap;
         mode = $urandom_range(0, 4);
         hold = $urandom_range(1, 8);
         gap  = $urandom_range(0, 6);
         for (int k = 0; k < hold; k++) begin
            @(negedge inClk);
            case (mode)
               0:       begin buttonA = 1'b1; buttonB = 1'b0; end
               1:       begin buttonA = 1'b0; buttonB = 1'b1; end
               2:       begin buttonA = 1'b1; buttonB = 1'b1; end
               3:       begin buttonA = 1'b0; buttonB = 1'b0; end
               default: begin buttonA = 1'($urandom_range(0, 1)); buttonB = 1'($urandom_range(0, 1)); end
            endcase
         end
         @(negedge inClk);
         buttonA = 1'b0;
         buttonB = 1'b0;
         cycles(gap);
      end

      cycles(12);
      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
